// File: rtl/cart_loader.sv
// cart_loader: streams an ioctl file download into cartridge memory,
// either as a raw .bin image or as a paged ST2 image.
module cart_loader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] cart_addr,
    output logic [7:0]  cart_data,
    output logic        cart_we,
    output logic        busy,
    output logic        cart_valid,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAW,
        S_HDR,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic        dl_q;
    logic        act_q, act_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  n_q, n_d;
    logic [16:0] cnt_q, cnt_d;
    logic [7:0]  page_q [64];
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    logic        pg_clr, pg_we;
    logic [5:0]  pg_idx;
    logic        rise, fall, acc;
    logic [25:0] addr_p1;
    logic [16:0] cnt_new;
    logic [16:0] blk;
    logic [5:0]  kidx;
    logic [7:0]  pg;
    logic        blk_ok;
    logic [7:0]  magic;

    // act_q marks a download that belongs to this loader
    assign rise    = ioctl_download & ~dl_q & (ioctl_index[5:0] == 6'd1);
    assign fall    = ~ioctl_download & dl_q & act_q;
    assign acc     = ioctl_wr & ioctl_download & act_q & ~rise;
    assign addr_p1 = {1'b0, ioctl_addr} + 26'd1;
    assign cnt_new = (|addr_p1[25:17]) ? '1 : addr_p1[16:0];
    assign blk     = ioctl_addr[24:8];
    assign kidx    = blk[5:0] - 6'd1;
    assign pg      = page_q[kidx];
    assign blk_ok  = (blk != 17'd0) && (blk < {9'd0, n_q});

    always_comb begin
        magic = 8'h52;
        unique case (ioctl_addr[1:0])
            2'd0: magic = 8'h52;
            2'd1: magic = 8'h43;
            2'd2: magic = 8'h41;
            2'd3: magic = 8'h32;
        endcase
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        ovf_d   = ovf_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        pg_clr  = 1'b0;
        pg_we   = 1'b0;
        pg_idx  = ioctl_addr[5:0];
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (rise) begin
            act_d  = 1'b1;
            ovf_d  = 1'b0;
            n_d    = 8'd0;
            cnt_d  = 17'd0;
            pg_clr = 1'b1;
            unique case (ioctl_index[7:6])
                2'd0:    state_d = S_RAW;
                2'd1:    state_d = S_HDR;
                default: state_d = S_ERR;
            endcase
        end else if (fall) begin
            act_d = 1'b0;
            unique case (state_q)
                S_RAW:  state_d = ovf_q ? S_ERR : S_DONE;
                S_DATA: state_d = (cnt_q < {1'b0, n_q, 8'h00}) ? S_ERR : S_DONE;
                S_IDLE, S_DONE: state_d = state_q;
                default: state_d = S_ERR;
            endcase
        end else if (acc) begin
            if (cnt_new > cnt_q)
                cnt_d = cnt_new;
            unique case (state_q)
                S_RAW: begin
                    if (ioctl_addr < 25'h0C00) begin
                        we_d   = 1'b1;
                        addr_d = 16'h0400 + ioctl_addr[15:0];
                        data_d = ioctl_dout;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                S_HDR: begin
                    if (ioctl_addr < 25'd4) begin
                        if (ioctl_dout != magic)
                            state_d = S_ERR;
                    end else if (ioctl_addr == 25'd4) begin
                        n_d = ioctl_dout;
                        if (ioctl_dout < 8'd2 || ioctl_dout > 8'd65)
                            state_d = S_ERR;
                    end else if (ioctl_addr[24:6] == 19'd1) begin
                        pg_we = 1'b1;
                    end else if (ioctl_addr == 25'd255) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    // page 0x00 marks a block that is not loaded
                    if (blk_ok && pg != 8'h00) begin
                        we_d   = 1'b1;
                        addr_d = {pg, ioctl_addr[7:0]};
                        data_d = ioctl_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    // dl_q resets high so a transfer still running at release is not seen as new
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dl_q    <= 1'b1;
            act_q   <= 1'b0;
            ovf_q   <= 1'b0;
            n_q     <= 8'd0;
            cnt_q   <= 17'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
            act_q   <= act_d;
            ovf_q   <= ovf_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++)
                page_q[i] <= 8'h00;
        end else if (pg_clr) begin
            for (int i = 0; i < 64; i++)
                page_q[i] <= 8'h00;
        end else if (pg_we) begin
            page_q[pg_idx] <= ioctl_dout;
        end
    end

    assign cart_we    = we_q;
    assign cart_addr  = addr_q;
    assign cart_data  = data_q;
    assign error      = (state_q == S_ERR);
    assign cart_valid = (state_q == S_DONE);
    assign busy       = (state_q == S_RAW) || (state_q == S_HDR) ||
                        (state_q == S_DATA) ||
                        ((state_q == S_ERR) && ioctl_download && act_q);

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: RAW, ST2, error paths, reset abort
// and back-to-back download edges.
module tb_cart_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic [15:0] cart_addr;
    logic [7:0]  cart_data;
    logic        cart_we;
    logic        busy;
    logic        cart_valid;
    logic        error;

    int pass_n = 0;
    int total_n = 0;

    int          wcnt = 0;
    logic [15:0] min_a = 16'hFFFF;
    logic [15:0] max_a = 16'h0000;
    logic [15:0] last_a = 16'h0000;
    logic [7:0]  mem [65536];

    cart_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .cart_addr      (cart_addr),
        .cart_data      (cart_data),
        .cart_we        (cart_we),
        .busy           (busy),
        .cart_valid     (cart_valid),
        .error          (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cart_we) begin
            wcnt++;
            mem[cart_addr] = cart_data;
            last_a = cart_addr;
            if (cart_addr < min_a) min_a = cart_addr;
            if (cart_addr > max_a) max_a = cart_addr;
        end
    end

    task automatic clr_mon();
        wcnt  = 0;
        min_a = 16'hFFFF;
        max_a = 16'h0000;
        last_a = 16'h0000;
    endtask

    task automatic dl_start(input logic [7:0] idx);
        @(posedge clk); #1;
        ioctl_index = idx;
        ioctl_download = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic dl_end();
        @(posedge clk); #1;
        ioctl_download = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
    endtask

    function automatic logic [7:0] st2_b(input int o, input logic [7:0] n,
                                         input logic [7:0] p0, input logic [7:0] p1,
                                         input logic [7:0] m0);
        if (o == 0) return m0;
        if (o == 1) return 8'h43;
        if (o == 2) return 8'h41;
        if (o == 3) return 8'h32;
        if (o == 4) return n;
        if (o == 64) return p0;
        if (o == 65) return p1;
        if (o < 256) return 8'h00;
        return 8'(o) ^ 8'h5A;
    endfunction

    task automatic send_st2(input logic [7:0] n, input logic [7:0] p0,
                            input logic [7:0] p1, input int nb, input logic [7:0] m0);
        for (int o = 0; o < nb; o++)
            send(25'(o), st2_b(o, n, p0, p1, m0));
    endtask

    task automatic test_reset();
        #1;
        total_n++;
        if ({cart_we, cart_addr, cart_data, busy, cart_valid, error} !== 28'd0)
            $display("FAIL reset_outputs got we=%b a=%h d=%h b=%b v=%b e=%b exp all 0",
                     cart_we, cart_addr, cart_data, busy, cart_valid, error);
        else pass_n++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_n++;
        if ({busy, cart_valid, error} !== 3'b000)
            $display("FAIL idle_after_reset got %b exp 000", {busy, cart_valid, error});
        else pass_n++;
    endtask

    task automatic test_raw();
        clr_mon();
        dl_start(8'h01);
        total_n++;
        if (busy !== 1'b1) $display("FAIL raw_busy got %b exp 1", busy);
        else pass_n++;
        @(posedge clk); #1;
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd0;
        ioctl_dout = 8'hAA;
        @(negedge clk);
        total_n++;
        if (cart_we !== 1'b0) $display("FAIL raw_latency_early got %b exp 0", cart_we);
        else pass_n++;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
        @(negedge clk);
        total_n++;
        if ({cart_we, cart_addr, cart_data} !== {1'b1, 16'h0400, 8'hAA})
            $display("FAIL raw_first_write got we=%b a=%h d=%h exp 1 0400 aa",
                     cart_we, cart_addr, cart_data);
        else pass_n++;
        send(25'd1, 8'hBB);
        send(25'd2, 8'hCC);
        dl_end();
        total_n++;
        if ({mem[16'h0401], mem[16'h0402], wcnt} !== {8'hBB, 8'hCC, 32'd3})
            $display("FAIL raw_writes got %h %h n=%0d exp bb cc n=3",
                     mem[16'h0401], mem[16'h0402], wcnt);
        else pass_n++;
        total_n++;
        if ({busy, cart_valid, error} !== 3'b010)
            $display("FAIL raw_end got bve=%b exp 010", {busy, cart_valid, error});
        else pass_n++;
    endtask

    task automatic test_other_index();
        clr_mon();
        dl_start(8'h02);
        send(25'd0, 8'h99);
        send(25'd1, 8'h98);
        total_n++;
        if ({wcnt, busy, cart_valid, error} !== {32'd0, 3'b010})
            $display("FAIL other_index got n=%0d bve=%b exp n=0 bve=010",
                     wcnt, {busy, cart_valid, error});
        else pass_n++;
        dl_end();
        total_n++;
        if (cart_valid !== 1'b1) $display("FAIL other_index_end got %b exp 1", cart_valid);
        else pass_n++;
    endtask

    task automatic test_st2();
        int mism;
        clr_mon();
        dl_start(8'h41);
        send_st2(8'd3, 8'h04, 8'h00, 772, 8'h52);
        dl_end();
        mism = 0;
        for (int j = 0; j < 256; j++)
            if (mem[16'h0400 + 16'(j)] !== (8'(j) ^ 8'h5A)) mism++;
        total_n++;
        if ({wcnt, min_a, max_a} !== {32'd256, 16'h0400, 16'h04FF})
            $display("FAIL st2_writes got n=%0d min=%h max=%h exp 256 0400 04ff",
                     wcnt, min_a, max_a);
        else pass_n++;
        total_n++;
        if (mism !== 0) $display("FAIL st2_data got %0d bad bytes exp 0", mism);
        else pass_n++;
        total_n++;
        if ({busy, cart_valid, error} !== 3'b010)
            $display("FAIL st2_end got bve=%b exp 010", {busy, cart_valid, error});
        else pass_n++;
    endtask

    task automatic test_bad_magic();
        clr_mon();
        dl_start(8'h41);
        send_st2(8'd3, 8'h04, 8'h00, 300, 8'h00);
        total_n++;
        if ({busy, cart_valid, error} !== 3'b101)
            $display("FAIL magic_mid got bve=%b exp 101", {busy, cart_valid, error});
        else pass_n++;
        dl_end();
        total_n++;
        if ({wcnt, busy, cart_valid, error} !== {32'd0, 3'b001})
            $display("FAIL magic_end got n=%0d bve=%b exp n=0 bve=001",
                     wcnt, {busy, cart_valid, error});
        else pass_n++;
    endtask

    task automatic test_bad_count();
        logic [7:0] ns [2];
        ns[0] = 8'd1;
        ns[1] = 8'd66;
        for (int i = 0; i < 2; i++) begin
            dl_start(8'h41);
            send_st2(ns[i], 8'h04, 8'h00, 5, 8'h52);
            total_n++;
            if (error !== 1'b1)
                $display("FAIL bad_count n=%0d got err=%b exp 1", ns[i], error);
            else pass_n++;
            dl_end();
        end
    endtask

    task automatic test_trunc();
        clr_mon();
        dl_start(8'h41);
        send_st2(8'd3, 8'h04, 8'h05, 600, 8'h52);
        dl_end();
        total_n++;
        if ({wcnt, min_a, max_a} !== {32'd344, 16'h0400, 16'h0557})
            $display("FAIL trunc_writes got n=%0d min=%h max=%h exp 344 0400 0557",
                     wcnt, min_a, max_a);
        else pass_n++;
        total_n++;
        if ({busy, cart_valid, error} !== 3'b001)
            $display("FAIL trunc_end got bve=%b exp 001", {busy, cart_valid, error});
        else pass_n++;
    endtask

    task automatic test_raw_overflow();
        clr_mon();
        dl_start(8'h01);
        for (int o = 0; o <= 'h0C00; o++)
            send(25'(o), 8'(o));
        total_n++;
        if ({wcnt, last_a, error} !== {32'h0C00, 16'h0FFF, 1'b0})
            $display("FAIL ovf_writes got n=%0h last=%h err=%b exp c00 0fff 0",
                     wcnt, last_a, error);
        else pass_n++;
        dl_end();
        total_n++;
        if ({busy, cart_valid, error} !== 3'b001)
            $display("FAIL ovf_end got bve=%b exp 001", {busy, cart_valid, error});
        else pass_n++;
    endtask

    task automatic test_reset_mid();
        dl_start(8'h41);
        send_st2(8'd3, 8'h04, 8'h05, 300, 8'h52);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total_n++;
        if ({cart_we, cart_addr, cart_data, busy, cart_valid, error} !== 28'd0)
            $display("FAIL reset_mid_outputs got we=%b a=%h d=%h bve=%b exp all 0",
                     cart_we, cart_addr, cart_data, {busy, cart_valid, error});
        else pass_n++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clr_mon();
        for (int o = 300; o < 768; o++)
            send(25'(o), st2_b(o, 8'd3, 8'h04, 8'h05, 8'h52));
        total_n++;
        if ({wcnt, busy} !== {32'd0, 1'b0})
            $display("FAIL reset_mid_ignored got n=%0d busy=%b exp 0 0", wcnt, busy);
        else pass_n++;
        dl_end();
        total_n++;
        if ({cart_valid, error} !== 2'b00)
            $display("FAIL reset_mid_idle got ve=%b exp 00", {cart_valid, error});
        else pass_n++;
        dl_start(8'h01);
        send(25'd5, 8'h77);
        dl_end();
        total_n++;
        if ({wcnt, last_a, mem[16'h0405], cart_valid} !== {32'd1, 16'h0405, 8'h77, 1'b1})
            $display("FAIL reset_mid_next got n=%0d a=%h d=%h v=%b exp 1 0405 77 1",
                     wcnt, last_a, mem[16'h0405], cart_valid);
        else pass_n++;
    endtask

    task automatic test_back_to_back();
        dl_start(8'h01);
        send(25'd0, 8'h11);
        @(posedge clk); #1;
        ioctl_download = 1'b0;
        @(posedge clk); #1;
        ioctl_download = 1'b1;
        ioctl_index = 8'h81;
        @(negedge clk);
        total_n++;
        if ({cart_valid, error} !== 2'b10)
            $display("FAIL b2b_fall got ve=%b exp 10", {cart_valid, error});
        else pass_n++;
        @(posedge clk); #1;
        total_n++;
        if ({busy, cart_valid, error} !== 3'b101)
            $display("FAIL b2b_rise got bve=%b exp 101", {busy, cart_valid, error});
        else pass_n++;
        dl_end();
        total_n++;
        if ({busy, cart_valid, error} !== 3'b001)
            $display("FAIL b2b_end got bve=%b exp 001", {busy, cart_valid, error});
        else pass_n++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_raw();
        test_other_index();
        test_st2();
        test_bad_magic();
        test_bad_count();
        test_trunc();
        test_raw_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
